// File: rtl/send_buffer_ring_if.sv
// Host write-window and RDMA drain-stream signals of the send buffer ring.
// The slave modport is the buffer; the master modport is the host/RDMA side.
interface send_buffer_ring_if #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 10,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_DEPTH = 32,
  parameter int LEN_W      = $clog2(SLOT_DEPTH + 1)
);
  logic [ADDR_W-1:0]   address;
  logic                clken;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic [DATA_W-1:0]   dataOut;
  logic                dataValid;
  logic                dataLast;
  logic                dataPop;
  logic [LEN_W-1:0]    slotLen;
  logic                ready;
  logic [NUM_SLOTS-1:0] slotValid;
  logic                overflowErr;
  logic                lengthErr;

  modport slave (
    input  address, clken, chipselect, write, writedata, byteenable, dataPop,
    output readdata, dataOut, dataValid, dataLast, slotLen, ready, slotValid,
           overflowErr, lengthErr
  );

  modport master (
    output address, clken, chipselect, write, writedata, byteenable, dataPop,
    input  readdata, dataOut, dataValid, dataLast, slotLen, ready, slotValid,
           overflowErr, lengthErr
  );
endinterface

// File: rtl/send_buffer_ring.sv
// Multi-slot send buffer: host fills and commits slots through a word window,
// the RDMA side drains committed slots in commit order as a show-ahead stream.
module send_buffer_ring #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 10,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_DEPTH = 32,
  parameter int LEN_W      = $clog2(SLOT_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  send_buffer_ring_if.slave bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int IDX_W  = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
  localparam int RAM_AW = PTR_W + IDX_W;
  localparam int OCC_W  = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [PTR_W-1:0]     wptr_reg, rptr_reg, wptr_inc, rptr_inc;
  logic [OCC_W-1:0]     occ_reg;
  logic                 ovf_reg, len_err_reg;
  logic [DATA_W-1:0]    readdata_reg, status_word;
  logic [DATA_W-1:0]    rd_data_reg;
  logic [DATA_W-1:0]    mem [0:(1 << RAM_AW) - 1];
  logic [RAM_AW-1:0]    rd_addr, wr_addr;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [LEN_W-1:0]     slot_len [NUM_SLOTS];

  logic access, ctrl_wr, rd_strobe, data_addr_ok, data_wr_req, data_wr, full;
  logic commit_req, len_bad, commit_ok, clear_req, set_ovf, set_len;
  logic data_valid, data_last, pop, last_pop, next_committed;
  logic [LEN_W-1:0] commit_len, cur_len;

  // Host window decode
  assign access       = bus.chipselect & bus.clken;
  assign ctrl_wr      = access & bus.write & (bus.address == '0);
  assign rd_strobe    = access & ~bus.write;
  assign data_addr_ok = (bus.address >= ADDR_W'(1)) && (bus.address <= ADDR_W'(SLOT_DEPTH));
  assign data_wr_req  = access & bus.write & data_addr_ok;
  assign full         = (occ_reg == OCC_W'(NUM_SLOTS));
  assign data_wr      = data_wr_req & ~full;
  assign wr_addr      = {wptr_reg, IDX_W'(bus.address - ADDR_W'(1))};

  assign commit_req = ctrl_wr & bus.writedata[30];
  assign clear_req  = ctrl_wr & bus.writedata[31];
  assign commit_len = bus.writedata[LEN_W-1:0];
  assign len_bad    = (commit_len == '0) || (commit_len > LEN_W'(SLOT_DEPTH));
  assign commit_ok  = commit_req & ~len_bad & ~full;
  assign set_ovf    = (data_wr_req | commit_req) & full;
  assign set_len    = commit_req & len_bad;

  assign wptr_inc = wptr_reg + PTR_W'(1);
  assign rptr_inc = rptr_reg + PTR_W'(1);

  // Drain-side status
  assign cur_len        = slot_len[rptr_reg];
  assign data_valid     = (state_reg == STREAM);
  assign data_last      = data_valid && (LEN_W'(idx_reg) == cur_len - LEN_W'(1));
  assign pop            = data_valid & bus.dataPop;
  assign last_pop       = pop & data_last;
  assign next_committed = slot_valid[rptr_inc] | (commit_ok & (wptr_reg == rptr_inc));

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic             valid_reg;
      logic [LEN_W-1:0] len_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          len_reg   <= '0;
        end else begin
          if (commit_ok && (wptr_reg == PTR_W'(gi))) begin
            valid_reg <= 1'b1;
            len_reg   <= commit_len;
          end else if (last_pop && (rptr_reg == PTR_W'(gi))) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign slot_valid[gi] = valid_reg;
      assign slot_len[gi]   = len_reg;
    end
  endgenerate

  // Slot storage: byte-merge write, registered read
  always_ff @(posedge clock) begin
    if (data_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.byteenable[b]) mem[wr_addr][b*8 +: 8] <= bus.writedata[b*8 +: 8];
      end
    end
    rd_data_reg <= mem[rd_addr];
  end

  // Read-ahead by idx+pop keeps one beat per cycle without bubbles
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rd_addr    = {rptr_reg, IDX_W'(0)};
    case (state_reg)
      IDLE: begin
        if (slot_valid[rptr_reg]) state_next = PRIME;
      end
      PRIME: begin
        state_next = STREAM;
        idx_next   = '0;
      end
      STREAM: begin
        rd_addr = {rptr_reg, idx_reg + IDX_W'(pop)};
        if (last_pop) begin
          idx_next   = '0;
          state_next = next_committed ? PRIME : IDLE;
        end else if (pop) begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status_word        = '0;
    status_word[7:0]   = 8'(occ_reg);
    status_word[15:8]  = 8'(wptr_reg);
    status_word[23:16] = 8'(rptr_reg);
    status_word[24]    = ovf_reg;
    status_word[25]    = len_err_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      occ_reg      <= '0;
      ovf_reg      <= 1'b0;
      len_err_reg  <= 1'b0;
      readdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (commit_ok) wptr_reg <= wptr_inc;
      if (last_pop)  rptr_reg <= rptr_inc;
      if (commit_ok && !last_pop)      occ_reg <= occ_reg + OCC_W'(1);
      else if (!commit_ok && last_pop) occ_reg <= occ_reg - OCC_W'(1);
      // A new error in the same word as a clear keeps the flag set
      ovf_reg     <= set_ovf | (ovf_reg & ~clear_req);
      len_err_reg <= set_len | (len_err_reg & ~clear_req);
      if (rd_strobe) readdata_reg <= (bus.address == '0) ? status_word : '0;
    end
  end

  assign bus.readdata    = readdata_reg;
  assign bus.dataOut     = data_valid ? rd_data_reg : '0;
  assign bus.dataValid   = data_valid;
  assign bus.dataLast    = data_last;
  assign bus.slotLen     = cur_len;
  assign bus.ready       = (occ_reg != '0);
  assign bus.slotValid   = slot_valid;
  assign bus.overflowErr = ovf_reg;
  assign bus.lengthErr   = len_err_reg;
endmodule

// File: tb/tb_send_buffer_ring.sv
// Scoreboard bench for send_buffer_ring: stimulus pushes expected beats,
// a negedge monitor pops and compares every consumed beat.
module tb_send_buffer_ring;
  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 10;
  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_DEPTH = 32;
  localparam int LEN_W      = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  send_buffer_ring_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS),
                        .SLOT_DEPTH(SLOT_DEPTH), .LEN_W(LEN_W)) bus ();

  send_buffer_ring #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS),
                     .SLOT_DEPTH(SLOT_DEPTH), .LEN_W(LEN_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int s, input int i);
    logic [31:0] w;
    w = {s[15:0], i[15:0]};
    return {8{w}};
  endfunction

  function automatic logic [DATA_W-1:0] st(input int occ, input int w, input int r,
                                           input logic ov, input logic le);
    logic [DATA_W-1:0] v;
    v = '0;
    v[7:0]   = occ[7:0];
    v[15:8]  = w[7:0];
    v[23:16] = r[7:0];
    v[24]    = ov;
    v[25]    = le;
    return v;
  endfunction

  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: every consumed beat must match the head of the scoreboard
  always @(negedge clock) begin : monitor
    beat_t e;
    if (reset && bus.dataValid && bus.dataPop) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected no beat", bus.dataOut);
      end else begin
        e = exp_q.pop_front();
        $display("beat data=%h last=%0b", bus.dataOut, bus.dataLast);
        chk("beat_data", bus.dataOut, e.data);
        chk("beat_last", DATA_W'(bus.dataLast), DATA_W'(e.last));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    bus.address    = '0;
    bus.clken      = 1'b0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] be);
    bus.address    = ADDR_W'(addr);
    bus.clken      = 1'b1;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = d;
    bus.byteenable = be;
    cyc();
    $display("write addr=%0d be=%h", addr, be);
    bus_idle();
  endtask

  task automatic ctrl(input logic clr, input logic cmt, input int len);
    logic [DATA_W-1:0] d;
    d = '0;
    d[31] = clr;
    d[30] = cmt;
    d[LEN_W-1:0] = len[LEN_W-1:0];
    wr(0, d, '1);
  endtask

  task automatic rd_status(input string name, input logic [DATA_W-1:0] exp);
    bus.address    = '0;
    bus.clken      = 1'b1;
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
    cyc();
    bus_idle();
    $display("status read %s = %h", name, bus.readdata[31:0]);
    chk(name, bus.readdata, exp);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.dataValid && n < 20) begin
      cyc();
      n++;
    end
    chk(name, DATA_W'(bus.dataValid), DATA_W'(1));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk(name, DATA_W'(exp_q.size()), DATA_W'(0));
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dataValid"}, DATA_W'(bus.dataValid), '0);
    chk({tag, "_dataLast"}, DATA_W'(bus.dataLast), '0);
    chk({tag, "_dataOut"}, bus.dataOut, '0);
    chk({tag, "_slotLen"}, DATA_W'(bus.slotLen), '0);
    chk({tag, "_ready"}, DATA_W'(bus.ready), '0);
    chk({tag, "_slotValid"}, DATA_W'(bus.slotValid), '0);
    chk({tag, "_readdata"}, bus.readdata, '0);
    chk({tag, "_overflowErr"}, DATA_W'(bus.overflowErr), '0);
    chk({tag, "_lengthErr"}, DATA_W'(bus.lengthErr), '0);
  endtask

  task automatic do_reset();
    bus_idle();
    bus.dataPop = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d, e;
    bus_idle();
    bus.dataPop = 1'b0;
    cyc();
    cyc();
    chk_reset_outputs("reset");
    reset = 1'b1;
    cyc();

    // Test 1: 4 beats, held pop, 2-cycle commit-to-data latency
    for (int i = 0; i < 4; i++) wr(i + 1, pat(1, i), '1);
    for (int i = 0; i < 4; i++) push(pat(1, i), i == 3);
    bus.dataPop = 1'b1;
    ctrl(1'b0, 1'b1, 4);
    chk("t1_ready", DATA_W'(bus.ready), DATA_W'(1));
    chk("t1_slotValid", DATA_W'(bus.slotValid), DATA_W'(8'h01));
    chk("t1_valid_n", DATA_W'(bus.dataValid), '0);
    cyc();
    chk("t1_valid_prime", DATA_W'(bus.dataValid), '0);
    cyc();
    chk("t1_valid_n2", DATA_W'(bus.dataValid), DATA_W'(1));
    chk("t1_slotLen", DATA_W'(bus.slotLen), DATA_W'(4));
    wait_drain("t1_drain");
    bus.dataPop = 1'b0;
    cyc();
    rd_status("t1_status", st(0, 1, 1, 1'b0, 1'b0));

    // Test 2: fill all slots, overflow, then drain with pointer wrap
    do_reset();
    for (int s = 0; s < NUM_SLOTS; s++) begin
      wr(1, pat(10 + s, 0), '1);
      ctrl(1'b0, 1'b1, 1);
      push(pat(10 + s, 0), 1'b1);
    end
    rd_status("t2_status_full", st(8, 0, 0, 1'b0, 1'b0));
    chk("t2_slotValid", DATA_W'(bus.slotValid), DATA_W'(8'hFF));
    wr(1, pat(99, 0), '1);
    chk("t2_ovf_write", DATA_W'(bus.overflowErr), DATA_W'(1));
    ctrl(1'b0, 1'b1, 1);
    rd_status("t2_status_9th", st(8, 0, 0, 1'b1, 1'b0));
    ctrl(1'b1, 1'b0, 0);
    chk("t2_ovf_clear", DATA_W'(bus.overflowErr), '0);
    bus.dataPop = 1'b1;
    wait_drain("t2_drain");
    bus.dataPop = 1'b0;
    cyc();
    cyc();
    rd_status("t2_status_empty", st(0, 0, 0, 1'b0, 1'b0));
    chk("t2_ready", DATA_W'(bus.ready), '0);

    // Test 3: length errors and clear
    ctrl(1'b0, 1'b1, 0);
    chk("t3_len0", DATA_W'(bus.lengthErr), DATA_W'(1));
    rd_status("t3_status_len0", st(0, 0, 0, 1'b0, 1'b1));
    ctrl(1'b1, 1'b0, 0);
    chk("t3_clear1", DATA_W'(bus.lengthErr), '0);
    ctrl(1'b0, 1'b1, SLOT_DEPTH + 1);
    chk("t3_len33", DATA_W'(bus.lengthErr), DATA_W'(1));
    rd_status("t3_status_len33", st(0, 0, 0, 1'b0, 1'b1));
    ctrl(1'b1, 1'b1, 0);
    chk("t3_clear_vs_err", DATA_W'(bus.lengthErr), DATA_W'(1));
    ctrl(1'b1, 1'b0, 0);
    chk("t3_clear2", DATA_W'(bus.lengthErr), '0);

    // Test 4: partial byteenable merge over an all-0xFF beat
    wr(1, '1, '1);
    d = {32{8'h55}};
    d[31:0] = 32'h1234_5678;
    wr(1, d, 32'h0000_000F);
    e = '1;
    e[31:0] = 32'h1234_5678;
    push(e, 1'b1);
    ctrl(1'b0, 1'b1, 1);
    bus.dataPop = 1'b1;
    wait_drain("t4_drain");
    bus.dataPop = 1'b0;

    // Test 5: commit of slot 1 on the same edge as the final pop of slot 0
    do_reset();
    wr(1, pat(50, 0), '1);
    wr(2, pat(50, 1), '1);
    ctrl(1'b0, 1'b1, 2);
    wr(1, pat(51, 0), '1);
    push(pat(50, 0), 1'b0);
    push(pat(50, 1), 1'b1);
    push(pat(51, 0), 1'b1);
    wait_valid("t5_valid0");
    bus.dataPop = 1'b1;
    cyc();
    chk("t5_last_before", DATA_W'(bus.dataLast), DATA_W'(1));
    ctrl(1'b0, 1'b1, 1);
    bus.dataPop = 1'b0;
    chk("t5_prime", DATA_W'(bus.dataValid), '0);
    rd_status("t5_status", st(1, 2, 1, 1'b0, 1'b0));
    chk("t5_valid1", DATA_W'(bus.dataValid), DATA_W'(1));
    bus.dataPop = 1'b1;
    wait_drain("t5_drain");
    bus.dataPop = 1'b0;

    // Test 6: reset on beat 2 of 4, then a fresh commit drains slot 0
    do_reset();
    for (int i = 0; i < 4; i++) wr(i + 1, pat(60, i), '1);
    ctrl(1'b0, 1'b1, 4);
    push(pat(60, 0), 1'b0);
    push(pat(60, 1), 1'b0);
    ctrl(1'b0, 1'b1, 0);
    wait_valid("t6_valid");
    bus.dataPop = 1'b1;
    cyc();
    cyc();
    bus.dataPop = 1'b0;
    rd_status("t6_status_mid", st(1, 1, 0, 1'b0, 1'b1));
    chk("t6_popped", DATA_W'(exp_q.size()), '0);
    reset = 1'b0;
    #1;
    chk_reset_outputs("t6_reset");
    cyc();
    reset = 1'b1;
    cyc();
    wr(1, pat(61, 0), '1);
    push(pat(61, 0), 1'b1);
    ctrl(1'b0, 1'b1, 1);
    bus.dataPop = 1'b1;
    wait_drain("t6_drain");
    bus.dataPop = 1'b0;
    cyc();
    rd_status("t6_status_end", st(0, 1, 1, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
